// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer: packs a 24-bit RGB888 pixel stream into 32-bit AXI4-Stream words
// (four pixels -> three words, byte order b,g,r, lane 0 = earliest byte), flushing
// partial words at end of line and realigning on an unexpected start of frame.
// Latency: one cycle from accepting the pixel that completes a word to tvalid.
// Backpressure: in_stream_ready drops whenever the single output slot is full and
// tready is low, and during the one-word FLUSH step after an overlong eol pixel.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   r, g, b                 pixel colour bytes
//   valid, sof, eol         pixel qualifier, first-of-frame, last-of-line
//   in_stream_ready         pixel accepted this cycle when valid is also high
//   out_stream_t*           AXI4-Stream master (tdata/tkeep/tlast/tuser/tvalid/tready)
//   frame_err               sticky: sof arrived while bytes were still pending
module rgb_stream_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        frame_err
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Packing state: acc holds cnt pending bytes in its low lanes; every byte above
  // lane cnt-1 is kept at zero so a new pixel can simply be OR-ed in.
  state_t      state;
  logic [47:0] acc;
  logic [2:0]  cnt;
  logic        user_pend;   // sof pixel bytes are pending and not yet in any word

  logic        slot_free;
  logic        accept;
  logic [2:0]  base_cnt;
  logic [2:0]  n;
  logic [47:0] base_acc;
  logic [47:0] pix_shifted;
  logic [47:0] merged;

  logic        emit;
  logic [31:0] word_dat;
  logic [3:0]  word_keep;
  logic        word_last;
  logic        word_user;
  logic [47:0] nxt_acc;
  logic [2:0]  nxt_cnt;
  state_t      nxt_state;
  logic        nxt_user_pend;
  logic        set_err;

  // Byte-enable mask for a word holding nb bytes starting at lane 0.
  function automatic logic [3:0] keep_for(input logic [2:0] nb);
    logic [3:0] k;
    case (nb)
      3'd0:    k = 4'h0;
      3'd1:    k = 4'h1;
      3'd2:    k = 4'h3;
      3'd3:    k = 4'h7;
      default: k = 4'hF;
    endcase
    return k;
  endfunction

  // Replace every lane not covered by keep with the pad byte.
  function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [3:0] keep);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = keep[i] ? d[8*i +: 8] : PAD_BYTE;
    end
    return w;
  endfunction

  assign slot_free       = !out_stream_tvalid || out_stream_tready;
  assign in_stream_ready = (state == RUN) && slot_free;
  assign accept          = valid && in_stream_ready;

  always_comb begin
    // An sof pixel always lands at lane 0; any pending bytes are discarded.
    base_cnt    = sof ? 3'd0 : cnt;
    base_acc    = sof ? 48'd0 : acc;
    pix_shifted = {24'd0, r, g, b} << {base_cnt, 3'b000};
    merged      = base_acc | pix_shifted;
    n           = base_cnt + 3'd3;

    emit          = 1'b0;
    word_dat      = merged[31:0];
    word_keep     = 4'hF;
    word_last     = 1'b0;
    word_user     = user_pend;
    nxt_acc       = acc;
    nxt_cnt       = cnt;
    nxt_state     = state;
    nxt_user_pend = user_pend;
    set_err       = 1'b0;

    case (state)
      RUN: begin
        if (accept) begin
          set_err   = sof && (cnt != 3'd0);
          // Any word produced by this accept contains bytes of this pixel.
          word_user = sof || user_pend;
          if (eol && (n <= 3'd4)) begin
            // Whole remainder of the line fits in one (possibly padded) word.
            emit          = 1'b1;
            word_keep     = keep_for(n);
            word_dat      = pad_word(merged[31:0], word_keep);
            word_last     = 1'b1;
            nxt_acc       = 48'd0;
            nxt_cnt       = 3'd0;
            nxt_user_pend = 1'b0;
          end else if (n >= 3'd4) begin
            // Full word out; leftover bytes shift down to lane 0. An eol here
            // leaves 1..2 bytes that go out as a separate tlast word in FLUSH.
            emit          = 1'b1;
            nxt_acc       = merged >> 32;
            nxt_cnt       = n - 3'd4;
            nxt_user_pend = 1'b0;
            if (eol) begin
              nxt_state = FLUSH;
            end
          end else begin
            nxt_acc       = merged;
            nxt_cnt       = n;
            nxt_user_pend = sof || user_pend;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          emit          = 1'b1;
          word_keep     = keep_for(cnt);
          word_dat      = pad_word(acc[31:0], word_keep);
          word_last     = 1'b1;
          word_user     = user_pend;
          nxt_acc       = 48'd0;
          nxt_cnt       = 3'd0;
          nxt_user_pend = 1'b0;
          nxt_state     = RUN;
        end
      end
      default: begin
        nxt_state = RUN;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state             <= RUN;
      acc               <= 48'd0;
      cnt               <= 3'd0;
      user_pend         <= 1'b0;
      frame_err         <= 1'b0;
      out_stream_tvalid <= 1'b0;
      out_stream_tdata  <= 32'd0;
      out_stream_tkeep  <= 4'h0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
    end else begin
      state     <= nxt_state;
      acc       <= nxt_acc;
      cnt       <= nxt_cnt;
      user_pend <= nxt_user_pend;
      if (set_err) begin
        frame_err <= 1'b1;
      end
      // emit only happens with the slot free, so a stalled word is never overwritten.
      if (emit) begin
        out_stream_tvalid <= 1'b1;
        out_stream_tdata  <= word_dat;
        out_stream_tkeep  <= word_keep;
        out_stream_tlast  <= word_last;
        out_stream_tuser  <= word_user;
      end else if (out_stream_tready) begin
        out_stream_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed bench for rgb_stream_packer: hand-computed words for short pixel
// sequences, eol flush, sof realignment, reset during flush, and a full
// 640-pixel line under random tready.
module tb_rgb_stream_packer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  r = 8'h00;
  logic [7:0]  g = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        valid = 1'b0;
  logic        sof = 1'b0;
  logic        eol = 1'b0;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;
  logic        frame_err;

  rgb_stream_packer #(.PAD_BYTE(8'h00)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .frame_err         (frame_err)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // tready: 0 = held low, 1 = held high, 2 = random 50%.
  int rdy_mode = 1;
  initial begin
    out_stream_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       out_stream_tready = 1'b0;
        1:       out_stream_tready = 1'b1;
        default: out_stream_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Capture every transferred word and track stability of stalled words.
  logic [31:0] q_dat[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];
  logic        q_user[$];
  int          hold_bad = 0;
  int          hold_cnt = 0;
  logic        stalled = 1'b0;
  logic [37:0] held = '0;

  always @(negedge aclk) begin
    if (stalled && out_stream_tvalid) begin
      hold_cnt <= hold_cnt + 1;
      if ({out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser} != held)
        hold_bad <= hold_bad + 1;
    end
    stalled <= out_stream_tvalid && !out_stream_tready;
    held    <= {out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser};
    if (out_stream_tvalid && out_stream_tready) begin
      q_dat.push_back(out_stream_tdata);
      q_keep.push_back(out_stream_tkeep);
      q_last.push_back(out_stream_tlast);
      q_user.push_back(out_stream_tuser);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clear_q();
    q_dat.delete();
    q_keep.delete();
    q_last.delete();
    q_user.delete();
  endtask

  // Present one pixel and return 1 time unit after the edge that accepted it.
  task automatic send_pix(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                          input logic s, input logic e);
    int t;
    r = rr; g = gg; b = bb; sof = s; eol = e; valid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!in_stream_ready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 64'(t), 64'd0);
    @(posedge aclk);
    #1;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                          input logic l, input logic u);
    chk({tag, "_vld"},  64'(out_stream_tvalid), 64'd1);
    chk({tag, "_dat"},  64'(out_stream_tdata),  64'(d));
    chk({tag, "_keep"}, 64'(out_stream_tkeep),  64'(k));
    chk({tag, "_last"}, 64'(out_stream_tlast),  64'(l));
    chk({tag, "_user"}, 64'(out_stream_tuser),  64'(u));
  endtask

  initial begin
    int t;
    int bad_keep, bad_last, bad_user, bad_bytes;
    logic [31:0] exp_w;
    logic [7:0]  bv;

    // Reset values
    tick(3);
    chk("rst_tvalid", 64'(out_stream_tvalid), 64'd0);
    chk("rst_tdata",  64'(out_stream_tdata),  64'd0);
    chk("rst_tkeep",  64'(out_stream_tkeep),  64'd0);
    chk("rst_tlast",  64'(out_stream_tlast),  64'd0);
    chk("rst_tuser",  64'(out_stream_tuser),  64'd0);
    chk("rst_ferr",   64'(frame_err),         64'd0);
    areset = 1'b0;
    chk("rst_ready",  64'(in_stream_ready),   64'd1);

    // Four pixels -> three words, sof on the first pixel
    clear_q();
    send_pix(8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
    chk("p0_no_word", 64'(out_stream_tvalid), 64'd0);
    send_pix(8'h44, 8'h55, 8'h66, 1'b0, 1'b0);
    chk_word("w0", 32'h66112233, 4'hF, 1'b0, 1'b1);
    send_pix(8'h77, 8'h88, 8'h99, 1'b0, 1'b0);
    chk_word("w1", 32'h88994455, 4'hF, 1'b0, 1'b0);
    send_pix(8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0);
    chk_word("w2", 32'hAABBCC77, 4'hF, 1'b0, 1'b0);
    tick(2);
    chk("quad_words", 64'(q_dat.size()), 64'd3);
    chk("quad_idle",  64'(out_stream_tvalid), 64'd0);
    chk("quad_ferr",  64'(frame_err), 64'd0);

    // Single pixel with eol
    send_pix(8'h11, 8'h22, 8'h33, 1'b0, 1'b1);
    chk_word("eol1", 32'h00112233, 4'h7, 1'b1, 1'b0);
    tick(1);

    // Two pixels, eol on the second: full word then FLUSH word
    send_pix(8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
    send_pix(8'h44, 8'h55, 8'h66, 1'b0, 1'b1);
    chk_word("eol2a", 32'h66112233, 4'hF, 1'b0, 1'b0);
    chk("flush_ready_low", 64'(in_stream_ready), 64'd0);
    tick(1);
    chk_word("eol2b", 32'h00004455, 4'h3, 1'b1, 1'b0);
    chk("flush_ready_back", 64'(in_stream_ready), 64'd1);
    tick(1);

    // Unexpected sof with a pixel pending; sof and eol together
    clear_q();
    send_pix(8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
    send_pix(8'h44, 8'h55, 8'h66, 1'b1, 1'b1);
    chk_word("sof_realign", 32'h00445566, 4'h7, 1'b1, 1'b1);
    chk("ferr_set", 64'(frame_err), 64'd1);
    tick(2);
    chk("sof_words", 64'(q_dat.size()), 64'd1);
    if (q_dat.size() > 0) chk("sof_first_word", 64'(q_dat[0]), 64'h00445566);
    chk("ferr_sticky", 64'(frame_err), 64'd1);

    // Reset in the middle of FLUSH
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    chk("ferr_cleared", 64'(frame_err), 64'd0);
    rdy_mode = 0;
    tick(1);
    clear_q();
    send_pix(8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
    send_pix(8'h44, 8'h55, 8'h66, 1'b0, 1'b1);
    chk("mid_flush_vld",   64'(out_stream_tvalid), 64'd1);
    chk("mid_flush_ready", 64'(in_stream_ready),   64'd0);
    areset = 1'b1;
    tick(1);
    chk("rst_flush_vld", 64'(out_stream_tvalid), 64'd0);
    areset = 1'b0;
    rdy_mode = 1;
    tick(5);
    chk("rst_flush_nowords", 64'(q_dat.size()), 64'd0);
    chk("rst_flush_ready",   64'(in_stream_ready), 64'd1);
    send_pix(8'h77, 8'h88, 8'h99, 1'b0, 1'b1);
    chk_word("post_rst", 32'h00778899, 4'h7, 1'b1, 1'b0);
    tick(2);
    chk("post_rst_words", 64'(q_dat.size()), 64'd1);

    // 640-pixel line under random backpressure; byte k of the line equals k mod 256
    clear_q();
    rdy_mode = 2;
    tick(1);
    for (int i = 0; i < 640; i++) begin
      send_pix(8'(3*i + 2), 8'(3*i + 1), 8'(3*i), 1'(i == 0), 1'(i == 639));
    end
    t = 0;
    while (q_dat.size() < 480 && t < 4000) begin
      tick(1);
      t++;
    end
    tick(10);
    chk("line_words", 64'(q_dat.size()), 64'd480);
    bad_keep = 0; bad_last = 0; bad_user = 0; bad_bytes = 0;
    for (int j = 0; j < q_dat.size(); j++) begin
      for (int k = 0; k < 4; k++) begin
        bv = 8'(4*j + k);
        exp_w[8*k +: 8] = bv;
      end
      if (q_dat[j] != exp_w) bad_bytes++;
      if (q_keep[j] != 4'hF) bad_keep++;
      if (q_last[j] != (j == 479)) bad_last++;
      if (q_user[j] != (j == 0)) bad_user++;
    end
    chk("line_bytes",    64'(bad_bytes), 64'd0);
    chk("line_keep",     64'(bad_keep),  64'd0);
    chk("line_last_pos", 64'(bad_last),  64'd0);
    chk("line_user_pos", 64'(bad_user),  64'd0);
    chk("line_ferr",     64'(frame_err), 64'd0);
    chk("hold_seen",     64'(hold_cnt > 0), 64'd1);
    chk("hold_stable",   64'(hold_bad),  64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_stream_packer.md
Name: rgb_stream_packer

Overview:
- Sits directly downstream of the fractal pixel generator and consumes its per-pixel handshake: r/g/b, valid, sof, eol.
- Converts the 24-bit RGB888 pixel stream into a 32-bit AXI4-Stream video interface for the VDMA: four pixels become three words.
- Marks start-of-frame on tuser and end-of-line on tlast.
- Flushes partial words at line ends and recovers byte alignment on an unexpected sof.

Parameters:
- PAD_BYTE, 8'h00, value written into unused byte lanes of a flushed partial word.

Ports:
- aclk  in  1  sole clock; all logic rising-edge.
- areset  in  1  synchronous, active-high reset.
- r  in  8  pixel red.
- g  in  8  pixel green.
- b  in  8  pixel blue.
- valid  in  1  pixel present on r/g/b/sof/eol.
- sof  in  1  pixel is first of frame; qualified by valid.
- eol  in  1  pixel is last of line; qualified by valid.
- in_stream_ready  out  1  packer accepts pixel this cycle.
- out_stream_tdata  out  32  packed bytes, lane 0 = earliest byte.
- out_stream_tkeep  out  4  valid byte lanes.
- out_stream_tlast  out  1  last word of a line.
- out_stream_tuser  out  1  first word of a frame.
- out_stream_tvalid  out  1  word valid.
- out_stream_tready  in  1  downstream accepts word.
- frame_err  out  1  sticky; sof arrived with pending bytes.

Behaviour:
- Clock and reset: one clock (aclk); synchronous active-high reset (areset).
- Reset values:
  - tvalid, tlast, tuser, frame_err = 0; tdata = 0; tkeep = 0.
  - Byte count cnt = 0; state = RUN.
  - in_stream_ready = 1 in the first cycle after reset deasserts.
- Reset mid-operation: all pending bytes and any held output word are discarded, with no flush.
- Byte order: each pixel is appended as three bytes in the order b, g, r, filling the lowest free lane first (little-endian).
- Storage:
  - 48-bit accumulator acc plus cnt, which takes values 0..3 between accepts.
  - One registered output slot.
- Handshakes:
  - Pixel is accepted when valid && in_stream_ready.
  - in_stream_ready = (state==RUN) && (!out_stream_tvalid || out_stream_tready).
  - Output word transfers when tvalid && tready.
  - tdata, tkeep, tlast and tuser are held stable while tvalid && !tready.
- Normal accept (eol=0):
  - Bytes are appended at lane cnt; new count n = cnt+3.
  - If n>=4: lanes 0..3 are loaded into the output slot with tkeep=4'hF and tvalid=1 on the next edge; acc shifts down 4 bytes; cnt = n-4.
  - Otherwise cnt = n and no word is emitted.
  - cnt sequence is 0→3→2→1→0: a 4-pixel cycle giving 3 words.
- Latency: one cycle from accepting the completing pixel to tvalid.
- eol accept, n<=4:
  - Emit one word holding n bytes, unused lanes = PAD_BYTE, tkeep = (1<<n)-1, tlast=1.
  - cnt = 0.
- eol accept, n>4:
  - Emit the full first word (tkeep=F, tlast=0), then enter FLUSH.
  - FLUSH: in_stream_ready=0. When the output slot frees, emit the remaining n-4 bytes padded, tkeep = (1<<(n-4))-1, tlast=1; cnt = 0; return to RUN.
- sof:
  - If cnt==0: normal accept.
  - If cnt!=0: pending bytes are dropped, frame_err is set (sticky until reset), and the sof pixel is appended at lane 0.
  - tuser=1 on the first word containing any byte of the sof pixel; tuser=0 on all other words.
- Simultaneous sof and eol on one pixel: both apply; the single padded word carries tuser=1 and tlast=1.
- Backpressure: tready low stalls in_stream_ready the same cycle a full slot exists; no pixel is lost or duplicated.
- 640-pixel lines: cnt returns to 0 at each eol with no padding; 480 words per line.

Test Plan:
- Reset, then P0=(r11,g22,b33), P1=(44,55,66), P2=(77,88,99), P3=(AA,BB,CC) with tready=1 → words 0x66112233, 0x88994455, 0xAABBCC77, all tkeep=F, one cycle after P1, P2, P3 respectively.
- sof=1 on P0 of the sequence above → tuser=1 on 0x66112233 only; tlast=0 throughout.
- Single pixel P0 with eol=1 → one word 0x00112233, tkeep=4'h7, tlast=1.
- P0, P1 with eol on P1:
  - Word 0x66112233 (tkeep=F, tlast=0), then 0x00004455 (tkeep=4'h3, tlast=1).
  - in_stream_ready low for exactly one cycle during FLUSH.
- Full 640-pixel line with eol, random tready (50%) → exactly 480 words, last tlast=1, tkeep always F; byte stream matches the model; tdata stable while stalled.
- P0 accepted, then sof pixel P1 → frame_err=1; first emitted word is built only from P1 with tuser=1.
- areset pulsed mid-FLUSH → tvalid=0 next cycle, cnt=0, no tlast word emitted afterwards.
